pc_gen: RTL and testbench

//  Parametrised program-counter generator for the fetch stage; successor to the basic PC register.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_align_chk.sv | 26 ++
 rtl/pc_gen.sv | 144 ++++++++++++++
 tb/tb_pc_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared types and constants for the program-counter generator.
//             Provides the BOOT/RUN/HALT state encoding, the two PC step
//             sizes and the default reset/trap vectors.
//  Revision : 1.0  initial release
// ============================================================================
package pc_pkg;

    // Controller state; explicit 2-bit width so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Sequential step for full-width and compressed instructions.
    localparam int unsigned INC_32 = 4;
    localparam int unsigned INC_16 = 2;

    // Default vectors used when the top is not overridden.
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_align_chk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pc_align_chk
//  Purpose  : Combinational misalignment check for a redirect target.
//             Only the two low address bits matter; with PC_RVC_EN defined
//             halfword targets are legal, so only bit 0 is examined.
//  Config   : PC_RVC_EN (compressed-instruction support)
//  Revision : 1.0  initial release
// ============================================================================
module pc_align_chk (
    input  logic [1:0] i_addr_lo,
    output logic       o_misalign
);

    // Mask of low address bits that must be zero for a legal target.
`ifdef PC_RVC_EN
    localparam logic [1:0] c_align_mask = 2'b01;
`else
    localparam logic [1:0] c_align_mask = 2'b11;
`endif

    assign o_misalign = |(i_addr_lo & c_align_mask);

endmodule : pc_align_chk
`default_nettype wire

// File: rtl/pc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Program-counter generator for the fetch stage. Holds the
//             architectural PC, selects trap / redirect / sequential next PC,
//             offers it to fetch over valid/ready, supports stall, halt and
//             resume, flags misaligned redirects and counts accepted fetches.
//  Config   : PC_RVC_EN adds instr_is_c (step of 2 for compressed
//             instructions) and relaxes the alignment check to bit 0.
//  Revision : 1.0  initial release
// ============================================================================
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_addr,
    input  logic             trap_valid,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             fetch_ready,
`ifdef PC_RVC_EN
    input  logic             instr_is_c,
`endif
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pc_next_seq,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    pc_state_e         r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_valid;
    logic              r_err;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic [XLEN-1:0]   w_inc;
    logic [XLEN-1:0]   w_seq;
    logic              w_accept;
    logic              w_misalign;

    // Step size for the sequential path; compressed instructions advance by 2.
    always_comb begin
`ifdef PC_RVC_EN
        w_inc = instr_is_c ? XLEN'(INC_16) : XLEN'(INC_32);
`else
        w_inc = XLEN'(INC_32);
`endif
    end

    // Sum wraps naturally at 2^XLEN.
    assign w_seq    = r_pc + w_inc;
    assign w_accept = r_valid & fetch_ready & ~stall;

    pc_align_chk u_align_chk (
        .i_addr_lo  (redirect_addr[1:0]),
        .o_misalign (w_misalign)
    );

    // State, PC selection, fetch counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_VECTOR;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            case (r_state)
                ST_BOOT: begin
                    // One bubble after reset, then start offering the reset vector.
                    r_state <= ST_RUN;
                    r_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (trap_valid) begin
                        // Trap beats everything, including a same-cycle halt request.
                        r_pc <= TRAP_VECTOR;
                    end else begin
                        if (redirect_valid) begin
                            r_pc  <= w_misalign ? TRAP_VECTOR : redirect_addr;
                            r_err <= w_misalign;
                        end else if (w_accept) begin
                            r_pc <= w_seq;
                        end
                        if (halt_req) begin
                            r_state  <= ST_HALT;
                            r_valid  <= 1'b0;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (trap_valid) begin
                        r_pc     <= TRAP_VECTOR;
                        r_state  <= ST_RUN;
                        r_valid  <= 1'b1;
                        r_halted <= 1'b0;
                    end else begin
                        // Debugger PC write: taken verbatim, no state change.
                        if (redirect_valid) begin
                            r_pc <= redirect_addr;
                        end
                        if (resume_req && !halt_req) begin
                            r_state  <= ST_RUN;
                            r_valid  <= 1'b1;
                            r_halted <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_BOOT;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid  = r_valid;
    assign fetch_pc     = r_pc;
    assign pc_next_seq  = w_seq;
    assign misalign_err = r_err;
    assign halted       = r_halted;
    assign fetch_cnt    = r_cnt;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Self-checking bench for pc_gen. A driver issues directed and
//             random cycles, advances a behavioural PC model and queues the
//             expected outputs; a monitor pops and compares after each edge.
//  Config   : PC_RVC_EN (connects instr_is_c, model uses 2/4 byte steps)
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid, trap_valid, halt_req, resume_req, fetch_ready;
    logic [31:0] redirect_addr;
`ifdef PC_RVC_EN
    logic        instr_is_c;
`endif
    logic        fetch_valid, misalign_err, halted;
    logic [31:0] fetch_pc, pc_next_seq, fetch_cnt;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .fetch_ready    (fetch_ready),
`ifdef PC_RVC_EN
        .instr_is_c     (instr_is_c),
`endif
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pc_next_seq    (pc_next_seq),
        .misalign_err   (misalign_err),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] nseq;
        logic        err;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    // Behavioural model: a "just out of reset" flag, a "halted" flag, PC and counter.
    bit          m_boot, m_halt, m_err;
    logic [31:0] m_pc, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_pc   = RV;
        m_cnt  = 32'd0;
    endtask

    // Assert reset at the current negedge, check immediately, release one cycle later.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc",     fetch_pc,            RV);
        chk("rst_valid",  32'(fetch_valid),    32'd0);
        chk("rst_cnt",    fetch_cnt,           32'd0);
        chk("rst_err",    32'(misalign_err),   32'd0);
        chk("rst_halted", 32'(halted),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle at the current negedge, predict the post-edge outputs, advance to next negedge.
    task automatic step(input bit rdy, input bit stl, input bit rv, input logic [31:0] ra,
                        input bit tv, input bit hr, input bit rr, input bit cc);
        bit          accepted, mis, running;
        logic [31:0] inc;
        fetch_ready    = rdy;
        stall          = stl;
        redirect_valid = rv;
        redirect_addr  = ra;
        trap_valid     = tv;
        halt_req       = hr;
        resume_req     = rr;
        inc = 32'd4;
`ifdef PC_RVC_EN
        instr_is_c = cc;
        if (cc) inc = 32'd2;
        mis = (ra % 2) != 0;
`else
        mis = (ra % 4) != 0;
        if (cc) inc = 32'd4;
`endif
        running  = !m_boot && !m_halt;
        accepted = running && rdy && !stl;
        if (accepted) m_cnt = m_cnt + 1;
        m_err = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (running) begin
            if (tv) begin
                m_pc = TV;
            end else begin
                if (rv) begin
                    if (mis) begin
                        m_pc  = TV;
                        m_err = 1'b1;
                    end else begin
                        m_pc = ra;
                    end
                end else if (accepted) begin
                    m_pc = m_pc + inc;
                end
                if (hr) m_halt = 1'b1;
            end
        end else begin
            if (tv) begin
                m_pc   = TV;
                m_halt = 1'b0;
            end else begin
                if (rv) m_pc = ra;
                if (rr && !hr) m_halt = 1'b0;
            end
        end
        q.push_back('{valid: !m_boot && !m_halt, pc: m_pc, nseq: m_pc + inc,
                      err: m_err, halted: m_halt, cnt: m_cnt});
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(rdy, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic redir(input bit rdy, input logic [31:0] ra);
        step(rdy, 1'b0, 1'b1, ra, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every queued expectation one step after the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid",  32'(fetch_valid),  32'(e.valid));
                chk("pc",     fetch_pc,          e.pc);
                chk("nseq",   pc_next_seq,       e.nseq);
                chk("err",    32'(misalign_err), 32'(e.err));
                chk("halted", 32'(halted),       32'(e.halted));
                chk("cnt",    fetch_cnt,         e.cnt);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'd0;
        trap_valid = 1'b0; halt_req = 1'b0; resume_req = 1'b0; fetch_ready = 1'b0;
`ifdef PC_RVC_EN
        instr_is_c = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // Boot bubble then sequential fetch 0x0, 0x4, 0x8.
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("t1_pc", fetch_pc, 32'h8);
        chk("t1_cnt", fetch_cnt, 32'd2);

        // Hold on not-ready and on stall.
        idle(1'b0); idle(1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_pc", fetch_pc, 32'h8);
        chk("t2_cnt", fetch_cnt, 32'd2);
        idle(1'b1);
        chk("t2_cnt3", fetch_cnt, 32'd3);

        // Trap beats redirect, stall ignored.
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_pc", fetch_pc, TV);
        chk("t3_err", 32'(misalign_err), 32'd0);

        // Halfword-aligned redirect target.
        redir(1'b0, 32'h42);
`ifdef PC_RVC_EN
        chk("t4_pc", fetch_pc, 32'h42);
`else
        chk("t4_pc", fetch_pc, TV);
        chk("t4_err", 32'(misalign_err), 32'd1);
`endif
        idle(1'b0);
        chk("t4_err_drop", 32'(misalign_err), 32'd0);

        // Halt, debugger PC write, resume.
        redir(1'b0, 32'h20);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_valid", 32'(fetch_valid), 32'd0);
        redir(1'b1, 32'h80);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_pc", fetch_pc, 32'h80);
        chk("t5_valid_back", 32'(fetch_valid), 32'd1);

        // Wrap at top of address space, then reset mid-run.
        redir(1'b0, 32'hFFFF_FFFC);
        idle(1'b1);
        chk("t6_wrap", fetch_pc, 32'h0);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit          rdy, stl, rv, tv, hr, rr, cc;
            logic [31:0] ra;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                rdy = $urandom_range(0, 3) != 0;
                stl = $urandom_range(0, 3) == 0;
                rv  = $urandom_range(0, 7) == 0;
                tv  = $urandom_range(0, 31) == 0;
                hr  = $urandom_range(0, 19) == 0;
                rr  = $urandom_range(0, 3) == 0;
                cc  = $urandom_range(0, 1) == 1;
                r   = $urandom;
                if ($urandom_range(0, 15) == 0)      ra = 32'hFFFF_FFFC;
                else if ($urandom_range(0, 3) == 0)  ra = r;
                else                                 ra = r & 32'hFFFF_FFFC;
                step(rdy, stl, rv, ra, tv, hr, rr, cc);
            end
        end

        idle(1'b0);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
